// File: rtl/scr1_dma_pkg.sv
// Shared types for the dmem word-copy initiator: dmem interface encodings (same values as
// scr1_memif.svh) plus the copy-engine FSM state and address step.
package scr1_dma_pkg;

    typedef enum logic {
        SCR1_MEM_CMD_RD = 1'b0,
        SCR1_MEM_CMD_WR = 1'b1
    } type_scr1_mem_cmd_e;

    typedef enum logic [1:0] {
        SCR1_MEM_WIDTH_BYTE  = 2'b00,
        SCR1_MEM_WIDTH_HWORD = 2'b01,
        SCR1_MEM_WIDTH_WORD  = 2'b10
    } type_scr1_mem_width_e;

    typedef enum logic [1:0] {
        SCR1_MEM_RESP_NOTRDY = 2'b00,
        SCR1_MEM_RESP_RDY_OK = 2'b01,
        SCR1_MEM_RESP_RDY_ER = 2'b10
    } type_scr1_mem_resp_e;

    typedef enum logic [2:0] {
        IDLE,
        CHK,
        RD_REQ,
        RD_WAIT,
        WR_REQ,
        WR_WAIT,
        FIN
    } type_scr1_dma_state_e;

    localparam int unsigned SCR1_DMA_WORD_INC = 4;

endpackage

// File: rtl/scr1_dmem_copy_initiator.sv
// Word-copy engine acting as a dmem initiator: copies len words from src to dst as
// read-then-write pairs with a single outstanding request.
module scr1_dmem_copy_initiator
    import scr1_dma_pkg::*;
#(
    parameter int unsigned LEN_W  = 16,
    parameter int unsigned AWIDTH = 32,
    parameter int unsigned DWIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic                 abort,
    input  logic [AWIDTH-1:0]    src_addr,
    input  logic [AWIDTH-1:0]    dst_addr,
    input  logic [LEN_W-1:0]     len,
    output logic                 busy,
    output logic                 done,
    output logic                 error,
    output logic [AWIDTH-1:0]    err_addr,
    output logic                 dmem_req,
    input  logic                 dmem_req_ack,
    output type_scr1_mem_cmd_e   dmem_cmd,
    output type_scr1_mem_width_e dmem_width,
    output logic [AWIDTH-1:0]    dmem_addr,
    output logic [DWIDTH-1:0]    dmem_wdata,
    input  logic [DWIDTH-1:0]    dmem_rdata,
    input  type_scr1_mem_resp_e  dmem_resp
);

    type_scr1_dma_state_e state_q, state_d;
    logic [AWIDTH-1:0]    src_q, src_d;
    logic [AWIDTH-1:0]    dst_q, dst_d;
    logic [LEN_W-1:0]     rem_q, rem_d;
    logic [DWIDTH-1:0]    wdata_q, wdata_d;
    logic                 error_q, error_d;
    logic [AWIDTH-1:0]    err_addr_q, err_addr_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            src_q      <= '0;
            dst_q      <= '0;
            rem_q      <= '0;
            wdata_q    <= '0;
            error_q    <= 1'b0;
            err_addr_q <= '0;
        end else begin
            state_q    <= state_d;
            src_q      <= src_d;
            dst_q      <= dst_d;
            rem_q      <= rem_d;
            wdata_q    <= wdata_d;
            error_q    <= error_d;
            err_addr_q <= err_addr_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        src_d      = src_q;
        dst_d      = dst_q;
        rem_d      = rem_q;
        wdata_d    = wdata_q;
        error_d    = error_q;
        err_addr_d = err_addr_q;
        case (state_q)
            IDLE: begin
                // start takes priority over abort here: abort is not looked at in IDLE
                if (start) begin
                    src_d   = src_addr;
                    dst_d   = dst_addr;
                    rem_d   = len;
                    error_d = 1'b0;
                    state_d = CHK;
                end
            end
            CHK: begin
                // Early exits still pass through FIN so done is a single registered-state pulse
                if (rem_q == '0) begin
                    state_d = FIN;
                end else if (src_q[1:0] != 2'b00) begin
                    error_d    = 1'b1;
                    err_addr_d = src_q;
                    state_d    = FIN;
                end else if (dst_q[1:0] != 2'b00) begin
                    error_d    = 1'b1;
                    err_addr_d = dst_q;
                    state_d    = FIN;
                end else begin
                    state_d = RD_REQ;
                end
            end
            RD_REQ: begin
                if (abort) begin
                    state_d = FIN;
                end else if (dmem_req_ack) begin
                    state_d = RD_WAIT;
                end
            end
            RD_WAIT: begin
                if (dmem_resp == SCR1_MEM_RESP_RDY_OK) begin
                    wdata_d = dmem_rdata;
                    state_d = WR_REQ;
                end else if (dmem_resp == SCR1_MEM_RESP_RDY_ER) begin
                    error_d    = 1'b1;
                    err_addr_d = src_q;
                    state_d    = FIN;
                end
            end
            WR_REQ: begin
                if (dmem_req_ack) begin
                    state_d = WR_WAIT;
                end
            end
            WR_WAIT: begin
                if (dmem_resp == SCR1_MEM_RESP_RDY_OK) begin
                    src_d = src_q + AWIDTH'(SCR1_DMA_WORD_INC);
                    dst_d = dst_q + AWIDTH'(SCR1_DMA_WORD_INC);
                    rem_d = rem_q - LEN_W'(1);
                    if ((rem_q == LEN_W'(1)) || abort) begin
                        state_d = FIN;
                    end else begin
                        state_d = RD_REQ;
                    end
                end else if (dmem_resp == SCR1_MEM_RESP_RDY_ER) begin
                    error_d    = 1'b1;
                    err_addr_d = dst_q;
                    state_d    = FIN;
                end
            end
            FIN:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // A read request withdrawn by abort is never presented to the responder
    assign dmem_req   = ((state_q == RD_REQ) && !abort) || (state_q == WR_REQ);
    assign dmem_cmd   = (state_q == WR_REQ) ? SCR1_MEM_CMD_WR : SCR1_MEM_CMD_RD;
    assign dmem_width = SCR1_MEM_WIDTH_WORD;
    assign dmem_addr  = (state_q == WR_REQ) ? dst_q :
                        (state_q == RD_REQ) ? src_q : '0;
    assign dmem_wdata = wdata_q;
    assign busy       = (state_q != IDLE);
    assign done       = (state_q == FIN);
    assign error      = error_q;
    assign err_addr   = err_addr_q;

endmodule

// File: tb/tb_scr1_dmem_copy_initiator.sv
// Directed bench for the dmem copy initiator against a small TCM-like responder with
// programmable ack/response wait states and write-error injection.
module tb_scr1_dmem_copy_initiator;
    import scr1_dma_pkg::*;

    logic                 clk = 1'b0;
    logic                 rst_n;
    logic                 start;
    logic                 abort;
    logic [31:0]          src_addr;
    logic [31:0]          dst_addr;
    logic [15:0]          len;
    logic                 busy;
    logic                 done;
    logic                 error;
    logic [31:0]          err_addr;
    logic                 dmem_req;
    logic                 dmem_req_ack;
    type_scr1_mem_cmd_e   dmem_cmd;
    type_scr1_mem_width_e dmem_width;
    logic [31:0]          dmem_addr;
    logic [31:0]          dmem_wdata;
    logic [31:0]          dmem_rdata;
    type_scr1_mem_resp_e  dmem_resp;

    scr1_dmem_copy_initiator #(
        .LEN_W  (16),
        .AWIDTH (32),
        .DWIDTH (32)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .abort        (abort),
        .src_addr     (src_addr),
        .dst_addr     (dst_addr),
        .len          (len),
        .busy         (busy),
        .done         (done),
        .error        (error),
        .err_addr     (err_addr),
        .dmem_req     (dmem_req),
        .dmem_req_ack (dmem_req_ack),
        .dmem_cmd     (dmem_cmd),
        .dmem_width   (dmem_width),
        .dmem_addr    (dmem_addr),
        .dmem_wdata   (dmem_wdata),
        .dmem_rdata   (dmem_rdata),
        .dmem_resp    (dmem_resp)
    );

    always #5 clk = ~clk;

    // Responder configuration, driven from the stimulus block
    int          ack_wait   = 0;
    int          resp_wait  = 0;
    int          err_wr_at  = -1;
    logic        pl_we      = 1'b0;
    logic [31:0] pl_addr    = '0;
    logic [31:0] pl_data    = '0;

    // Responder / monitor state, owned by the always block below
    logic [31:0] mem [0:255];
    int          ack_cnt    = 0;
    int          resp_cnt   = 0;
    logic        pending    = 1'b0;
    logic        pend_err   = 1'b0;
    logic [31:0] pend_addr  = '0;
    int          rd_cnt     = 0;
    int          wr_cnt     = 0;
    int          req_cycles = 0;
    int          stab_viol  = 0;
    logic [31:0] cmd_log    = '0;
    logic        hold_q     = 1'b0;
    logic [31:0] hold_addr  = '0;
    logic [31:0] hold_wdata = '0;
    logic        hold_cmd   = 1'b0;

    assign dmem_req_ack = rst_n && dmem_req && (ack_cnt >= ack_wait);
    assign dmem_rdata   = mem[pend_addr[9:2]];
    assign dmem_resp    = !(rst_n && pending && (resp_cnt >= resp_wait)) ? SCR1_MEM_RESP_NOTRDY :
                          pend_err ? SCR1_MEM_RESP_RDY_ER : SCR1_MEM_RESP_RDY_OK;

    always @(posedge clk) begin
        if (pl_we) mem[pl_addr[9:2]] <= pl_data;
        if (!rst_n) begin
            pending  <= 1'b0;
            ack_cnt  <= 0;
            resp_cnt <= 0;
            hold_q   <= 1'b0;
        end else begin
            if (dmem_req) req_cycles <= req_cycles + 1;
            if (hold_q && (!dmem_req || dmem_addr != hold_addr || dmem_wdata != hold_wdata ||
                           dmem_cmd != type_scr1_mem_cmd_e'(hold_cmd)))
                stab_viol <= stab_viol + 1;
            hold_q     <= dmem_req && !dmem_req_ack;
            hold_addr  <= dmem_addr;
            hold_wdata <= dmem_wdata;
            hold_cmd   <= dmem_cmd;
            if (pending && dmem_resp != SCR1_MEM_RESP_NOTRDY) pending <= 1'b0;
            else if (pending) resp_cnt <= resp_cnt + 1;
            if (dmem_req && dmem_req_ack) begin
                ack_cnt   <= 0;
                pending   <= 1'b1;
                resp_cnt  <= 0;
                pend_addr <= dmem_addr;
                cmd_log   <= {cmd_log[30:0], dmem_cmd == SCR1_MEM_CMD_WR};
                if (dmem_cmd == SCR1_MEM_CMD_WR) begin
                    wr_cnt <= wr_cnt + 1;
                    if (wr_cnt + 1 == err_wr_at) begin
                        pend_err <= 1'b1;
                    end else begin
                        pend_err <= 1'b0;
                        mem[dmem_addr[9:2]] <= dmem_wdata;
                    end
                end else begin
                    rd_cnt   <= rd_cnt + 1;
                    pend_err <= 1'b0;
                end
            end else if (dmem_req) begin
                ack_cnt <= ack_cnt + 1;
            end else begin
                ack_cnt <= 0;
            end
        end
    end

    int n_cmp  = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic preload(input logic [31:0] a, input logic [31:0] d);
        pl_we   = 1'b1;
        pl_addr = a;
        pl_data = d;
        @(posedge clk);
        #1;
        pl_we = 1'b0;
    endtask

    task automatic start_copy(input logic [31:0] s, input logic [31:0] d, input logic [15:0] l);
        src_addr = s;
        dst_addr = d;
        len      = l;
        start    = 1'b1;
    endtask

    // Returns the number of edges until done is seen; a bound of 300 marks a hang
    task automatic wait_done(output int c);
        c = 0;
        do begin
            tick();
            c++;
        end while (!done && c < 300);
    endtask

    int c, rd0, wr0, rq0;

    initial begin
        rst_n = 1'b0; start = 1'b0; abort = 1'b0;
        src_addr = '0; dst_addr = '0; len = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_req", 32'(dmem_req), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_error", 32'(error), 0);
        chk("rst_err_addr", err_addr, 0);
        chk("rst_cmd", 32'(dmem_cmd), 32'(SCR1_MEM_CMD_RD));
        chk("rst_addr", dmem_addr, 0);
        chk("rst_wdata", dmem_wdata, 0);
        rst_n = 1'b1;
        preload(32'h100, 32'hA);
        preload(32'h104, 32'hB);
        preload(32'h108, 32'hC);
        preload(32'h10C, 32'hD);

        // Test 1: zero-wait copy of three words
        rd0 = rd_cnt; wr0 = wr_cnt;
        start_copy(32'h100, 32'h200, 16'd3);
        chk("t1_busy_start_cycle", 32'(busy), 0);
        tick();
        chk("t1_busy_next", 32'(busy), 1);
        wait_done(c);
        chk("t1_done_cycle", c + 1, 14);
        chk("t1_error", 32'(error), 0);
        chk("t1_rd", rd_cnt - rd0, 3);
        chk("t1_wr", wr_cnt - wr0, 3);
        chk("t1_cmd_order", cmd_log & 32'h3F, 32'h15);
        chk("t1_w0", mem[8'h80], 32'hA);
        chk("t1_w1", mem[8'h81], 32'hB);
        chk("t1_w2", mem[8'h82], 32'hC);
        chk("t1_width", 32'(dmem_width), 32'(SCR1_MEM_WIDTH_WORD));
        tick();
        chk("t1_done_pulse", 32'(done), 0);
        chk("t1_idle", 32'(busy), 0);

        // Test 2: ack held off 2 cycles, response NOTRDY 3 cycles
        ack_wait = 2; resp_wait = 3;
        rd0 = rd_cnt; wr0 = wr_cnt;
        start_copy(32'h100, 32'h300, 16'd3);
        wait_done(c);
        chk("t2_done_cycle", c, 44);
        chk("t2_stable", stab_viol, 0);
        chk("t2_rd", rd_cnt - rd0, 3);
        chk("t2_wr", wr_cnt - wr0, 3);
        chk("t2_w0", mem[8'hC0], 32'hA);
        chk("t2_w2", mem[8'hC2], 32'hC);
        ack_wait = 0; resp_wait = 0;
        tick();

        // Test 3: zero length and misaligned addresses
        rq0 = req_cycles;
        start_copy(32'h100, 32'h200, 16'd0);
        wait_done(c);
        chk("t3_len0_done", c, 2);
        chk("t3_len0_err", 32'(error), 0);
        tick();
        start_copy(32'h102, 32'h201, 16'd2);
        wait_done(c);
        chk("t3_src_done", c, 2);
        chk("t3_src_err", 32'(error), 1);
        chk("t3_src_err_addr", err_addr, 32'h102);
        tick();
        start_copy(32'h100, 32'h203, 16'd2);
        wait_done(c);
        chk("t3_dst_err_addr", err_addr, 32'h203);
        chk("t3_no_req", req_cycles - rq0, 0);
        tick();

        // Test 4: error response on the second write
        rd0 = rd_cnt; wr0 = wr_cnt;
        err_wr_at = wr_cnt + 2;
        start_copy(32'h100, 32'h200, 16'd3);
        tick();
        chk("t4_err_cleared", 32'(error), 0);
        wait_done(c);
        chk("t4_done_cycle", c + 1, 10);
        chk("t4_error", 32'(error), 1);
        chk("t4_err_addr", err_addr, 32'h204);
        err_wr_at = -1;
        repeat (4) tick();
        chk("t4_rd", rd_cnt - rd0, 2);
        chk("t4_wr", wr_cnt - wr0, 2);
        start_copy(32'h100, 32'h2C0, 16'd1);
        tick();
        chk("t4_restart_clears", 32'(error), 0);
        wait_done(c);
        chk("t4_restart_done", c + 1, 6);
        chk("t4_restart_data", mem[8'hB0], 32'hA);

        // Test 5: abort during the first read response wait
        tick();
        rd0 = rd_cnt; wr0 = wr_cnt;
        start_copy(32'h100, 32'h240, 16'd4);
        repeat (3) tick();
        abort = 1'b1;
        wait_done(c);
        abort = 1'b0;
        chk("t5_done_cycle", c + 3, 6);
        chk("t5_rd", rd_cnt - rd0, 1);
        chk("t5_wr", wr_cnt - wr0, 1);
        chk("t5_error", 32'(error), 0);
        chk("t5_data", mem[8'h90], 32'hA);

        // Start and abort together in IDLE: start wins
        tick();
        rd0 = rd_cnt; wr0 = wr_cnt;
        start_copy(32'h104, 32'h260, 16'd1);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        wait_done(c);
        chk("t5b_done_cycle", c + 1, 6);
        chk("t5b_pairs", (rd_cnt - rd0) + (wr_cnt - wr0), 2);
        chk("t5b_data", mem[8'h98], 32'hB);

        // Test 6: reset while a write request is pending
        tick();
        start_copy(32'h100, 32'h280, 16'd2);
        repeat (4) tick();
        chk("t6_in_wr_req", 32'(dmem_req), 1);
        chk("t6_in_wr_cmd", 32'(dmem_cmd), 32'(SCR1_MEM_CMD_WR));
        rst_n = 1'b0;
        #1;
        chk("t6_rst_req", 32'(dmem_req), 0);
        chk("t6_rst_busy", 32'(busy), 0);
        chk("t6_rst_addr", dmem_addr, 0);
        repeat (2) tick();
        rst_n = 1'b1;
        rq0 = req_cycles;
        repeat (3) tick();
        chk("t6_idle_busy", 32'(busy), 0);
        chk("t6_idle_no_req", req_cycles - rq0, 0);
        start_copy(32'h100, 32'h280, 16'd2);
        wait_done(c);
        chk("t6_done_cycle", c, 10);
        chk("t6_w0", mem[8'hA0], 32'hA);
        chk("t6_w1", mem[8'hA1], 32'hB);
        chk("t6_error", 32'(error), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
